// File: rtl/matrix_ops_pkg.sv
// Shared types and helpers for the matrix_ops compute leaves.
// Holds the FSM state encoding, flat-bus element offsets and counter sizing.
package matrix_ops_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit offset of element [r][c] in a row-major flat bus
  function automatic int elem_off(input int r, input int c, input int width, input int dw);
    return (r * width + c) * dw;
  endfunction

  // Counter width; never below one bit, even for a dimension of 1
  function automatic int cnt_w(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/matrix_mult_vector_if.sv
// Operand/result bus of the matrix x vector multiplier.
interface matrix_mult_vector_if #(
  parameter int MATRIX_WIDTH  = 2,
  parameter int MATRIX_HEIGHT = 2,
  parameter int DATA_WIDTH    = 8
);
  logic                                         i_calc;
  logic [MATRIX_WIDTH*MATRIX_HEIGHT*DATA_WIDTH-1:0] i_matrix;
  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]           i_vector;
  logic [MATRIX_HEIGHT*DATA_WIDTH-1:0]          o_result;
  logic                                         o_ready;

  modport master (output i_calc, i_matrix, i_vector, input  o_result, o_ready);
  modport slave  (input  i_calc, i_matrix, i_vector, output o_result, o_ready);
endinterface

// File: rtl/matrix_mult_vector_mac.sv
// Single multiply-accumulate: sum = acc + a*b, everything truncated to DATA_WIDTH.
module matrix_mult_vector_mac #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] acc,
  output logic [DATA_WIDTH-1:0] sum
);
  // Context width is DATA_WIDTH, so the product and sum wrap naturally
  assign sum = acc + a * b;
endmodule

// File: rtl/matrix_mult_vector.sv
// Sequential unsigned R = M * v, one MAC per clock, start on i_calc level,
// completion on o_ready; a new start needs i_calc to drop and rise again.
module matrix_mult_vector
  import matrix_ops_pkg::*;
#(
  parameter int MATRIX_WIDTH  = 2,
  parameter int MATRIX_HEIGHT = 2,
  parameter int MATRIX_WEIGHT = MATRIX_WIDTH * MATRIX_HEIGHT,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 i_rst,
  matrix_mult_vector_if.slave  bus
);
  localparam int RW = cnt_w(MATRIX_HEIGHT);
  localparam int CW = cnt_w(MATRIX_WIDTH);
  localparam int MB = MATRIX_WEIGHT * DATA_WIDTH;
  localparam int VB = MATRIX_WIDTH * DATA_WIDTH;
  localparam int RB = MATRIX_HEIGHT * DATA_WIDTH;

  if (MATRIX_WEIGHT != MATRIX_WIDTH * MATRIX_HEIGHT) begin : g_bad_weight
    $error("MATRIX_WEIGHT must equal MATRIX_WIDTH*MATRIX_HEIGHT");
  end

  state_e                state_q, state_nxt;
  logic [MB-1:0]         mat_q, mat_nxt;
  logic [VB-1:0]         vec_q, vec_nxt;
  logic [RB-1:0]         res_q, res_nxt;
  logic [DATA_WIDTH-1:0] acc_q, acc_nxt;
  logic [RW-1:0]         r_q, r_nxt;
  logic [CW-1:0]         c_q, c_nxt;
  logic                  rdy_q, rdy_nxt;
  logic [DATA_WIDTH-1:0] a_sel, b_sel, mac_out;

  // Operand mux from the latched copies, decoded against the counters
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int r = 0; r < MATRIX_HEIGHT; r++)
      for (int c = 0; c < MATRIX_WIDTH; c++)
        if (r_q == RW'(r) && c_q == CW'(c))
          a_sel = mat_q[elem_off(r, c, MATRIX_WIDTH, DATA_WIDTH) +: DATA_WIDTH];
    for (int c = 0; c < MATRIX_WIDTH; c++)
      if (c_q == CW'(c))
        b_sel = vec_q[c*DATA_WIDTH +: DATA_WIDTH];
  end

  matrix_mult_vector_mac #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
    .a   (a_sel),
    .b   (b_sel),
    .acc (acc_q),
    .sum (mac_out)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      vec_q   <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      mat_q   <= mat_nxt;
      vec_q   <= vec_nxt;
      res_q   <= res_nxt;
      acc_q   <= acc_nxt;
      r_q     <= r_nxt;
      c_q     <= c_nxt;
      rdy_q   <= rdy_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    mat_nxt   = mat_q;
    vec_nxt   = vec_q;
    res_nxt   = res_q;
    acc_nxt   = acc_q;
    r_nxt     = r_q;
    c_nxt     = c_q;
    rdy_nxt   = rdy_q;
    unique case (state_q)
      IDLE: begin
        rdy_nxt = 1'b0;
        if (bus.i_calc) begin
          mat_nxt   = bus.i_matrix;
          vec_nxt   = bus.i_vector;
          res_nxt   = '0;
          acc_nxt   = '0;
          r_nxt     = '0;
          c_nxt     = '0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (c_q == CW'(MATRIX_WIDTH - 1)) begin
          for (int r = 0; r < MATRIX_HEIGHT; r++)
            if (r_q == RW'(r))
              res_nxt[r*DATA_WIDTH +: DATA_WIDTH] = mac_out;
          acc_nxt = '0;
          c_nxt   = '0;
          if (r_q == RW'(MATRIX_HEIGHT - 1)) begin
            rdy_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            r_nxt = r_q + RW'(1);
          end
        end else begin
          acc_nxt = mac_out;
          c_nxt   = c_q + CW'(1);
        end
      end
      DONE: begin
        if (!bus.i_calc) begin
          rdy_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_result = res_q;
  assign bus.o_ready  = rdy_q;

endmodule

// File: tb/tb_matrix_mult_vector.sv
// Directed bench for the 2x2 / 8-bit matrix x vector multiplier.
module tb_matrix_mult_vector;
  logic clk = 1'b0;
  logic i_rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  matrix_mult_vector_if #(.MATRIX_WIDTH(2), .MATRIX_HEIGHT(2), .DATA_WIDTH(8)) bus ();

  matrix_mult_vector #(.MATRIX_WIDTH(2), .MATRIX_HEIGHT(2), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] mat;
    logic [15:0] vec;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Counts edges from the start edge until o_ready is seen; bounded
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.o_ready && n < 20);
  endtask

  task automatic start(input logic [31:0] m, input logic [15:0] v);
    @(negedge clk);
    bus.i_matrix = m;
    bus.i_vector = v;
    bus.i_calc   = 1'b1;
  endtask

  task automatic finish_drop(input string nm);
    @(negedge clk);
    bus.i_calc = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_drop_rdy"}, {31'd0, bus.o_ready}, 32'd0);
  endtask

  task automatic run(input vec_t t);
    int n;
    start(t.mat, t.vec);
    wait_ready(n);
    chk({t.name, "_lat"}, n, 32'd5);
    chk({t.name, "_res"}, {16'd0, bus.o_result}, {16'd0, t.exp});
    finish_drop(t.name);
  endtask

  vec_t tbl [5];

  initial begin
    int n;
    tbl[0] = '{"wrap",  32'h0203060E, 16'h0A0E, 16'h3E00};
    tbl[1] = '{"plain", 32'h04030201, 16'h0605, 16'h2711};
    tbl[2] = '{"maxv",  32'hFFFFFFFF, 16'hFFFF, 16'h0202};
    tbl[3] = '{"mixed", 32'h00032010, 16'h0102, 16'h0640};
    tbl[4] = '{"zerov", 32'hDEADBEEF, 16'h0000, 16'h0000};

    bus.i_calc   = 1'b0;
    bus.i_matrix = '0;
    bus.i_vector = '0;
    i_rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", {16'd0, bus.o_result}, 32'd0);
    chk("rst_rdy", {31'd0, bus.o_ready}, 32'd0);
    @(negedge clk);
    i_rst = 1'b0;

    for (int i = 0; i < 5; i++) run(tbl[i]);

    // Operands change while computing; latched copies must be used
    start(32'h04030201, 16'h0605);
    @(posedge clk);
    @(negedge clk);
    bus.i_matrix = '1;
    bus.i_vector = '1;
    wait_ready(n);
    n++;
    chk("stab_lat", n, 32'd5);
    chk("stab_res", {16'd0, bus.o_result}, 32'h2711);

    // Holding i_calc in DONE keeps the result and does not restart
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rdy", {31'd0, bus.o_ready}, 32'd1);
    chk("hold_res", {16'd0, bus.o_result}, 32'h2711);
    finish_drop("hold");
    chk("idle_res_kept", {16'd0, bus.o_result}, 32'h2711);
    run('{"restart", 32'h0203060E, 16'h0A0E, 16'h3E00});

    // Reset after row 0 has been written aborts everything asynchronously
    start(32'h04030201, 16'h0605);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_row0", {16'd0, bus.o_result}, 32'h0011);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_res", {16'd0, bus.o_result}, 32'd0);
    chk("mid_rst_rdy", {31'd0, bus.o_ready}, 32'd0);
    @(negedge clk);
    bus.i_calc = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    run('{"post_rst", 32'h00032010, 16'h0102, 16'h0640});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
